// File: rtl/ftdi_tx_frame_source.sv
// ftdi_tx_frame_source: framed 32-bit test traffic (header, counting payload, XOR checksum)
// on a valid/ready stream for the FT601 write path.
module ftdi_tx_frame_source #(
  parameter int          PAYLOAD_WORDS = 255,
  parameter int          GAP_CYCLES    = 4,
  parameter logic [15:0] HEADER_MAGIC  = 16'hA5A5
) (
  input  logic        i_ftdi_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic [3:0]  o_be,
  output logic        o_last,
  output logic [15:0] o_frame_count,
  output logic        o_busy,
  output logic [2:0]  o_fsm
);
  typedef enum logic [2:0] {IDLE = 3'd0, HEADER = 3'd1, PAYLOAD = 3'd2, CHECKSUM = 3'd3, GAP = 3'd4} state_t;
  state_t      r_state;
  logic        r_valid;
  logic        r_last;
  logic [31:0] r_data;
  logic [31:0] r_pcnt;
  logic [31:0] r_csum;
  logic [15:0] r_idx;
  logic [7:0]  r_gap;
  logic [15:0] r_frame_count;
  logic [31:0] w_hdr;
  logic [31:0] w_pnext;
  assign w_hdr         = {HEADER_MAGIC, r_frame_count};
  assign w_pnext       = r_pcnt + 32'd1;
  assign o_valid       = r_valid;
  assign o_data        = r_data;
  assign o_be          = {4{r_valid}};
  assign o_last        = r_last;
  assign o_frame_count = r_frame_count;
  assign o_busy        = r_state != IDLE;
  assign o_fsm         = r_state;
  // o_valid is high in every state that can see i_ready, so i_ready alone marks a transfer there
  always_ff @(posedge i_ftdi_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_valid       <= 1'b0;
      r_last        <= 1'b0;
      r_data        <= 32'd0;
      r_pcnt        <= 32'd0;
      r_csum        <= 32'd0;
      r_idx         <= 16'd0;
      r_gap         <= 8'd0;
      r_frame_count <= 16'd0;
    end else begin
      case (r_state)
        IDLE: if (i_enable) begin
          r_state <= HEADER;
          r_valid <= 1'b1;
          r_data  <= w_hdr;
          r_csum  <= w_hdr;
          r_last  <= 1'b0;
        end
        HEADER: if (i_ready) begin
          r_state <= PAYLOAD;
          r_data  <= r_pcnt;
          r_csum  <= r_csum ^ r_pcnt;
          r_idx   <= 16'd0;
        end
        PAYLOAD: if (i_ready) begin
          r_pcnt <= w_pnext;
          if (r_idx == 16'(PAYLOAD_WORDS - 1)) begin
            r_state <= CHECKSUM;
            r_data  <= r_csum;
            r_last  <= 1'b1;
          end else begin
            r_idx  <= r_idx + 16'd1;
            r_data <= w_pnext;
            r_csum <= r_csum ^ w_pnext;
          end
        end
        CHECKSUM: if (i_ready) begin
          r_frame_count <= r_frame_count + 16'd1;
          r_valid       <= 1'b0;
          r_last        <= 1'b0;
          r_data        <= 32'd0;
          r_gap         <= 8'd0;
          r_state       <= GAP_CYCLES > 0 ? GAP : IDLE;
        end
        GAP: begin
          r_gap <= r_gap + 8'd1;
          if (r_gap == 8'(GAP_CYCLES - 1)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ftdi_tx_frame_source.sv
// tb_ftdi_tx_frame_source: scoreboard bench for a short-frame/gapped instance and a
// 255-word/gapless instance sharing one clock and reset.
module tb_ftdi_tx_frame_source;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en[2];
  logic        rdy[2];
  logic        v[2];
  logic        lst[2];
  logic        bsy[2];
  logic [31:0] d[2];
  logic [3:0]  be[2];
  logic [15:0] fc[2];
  logic [2:0]  fsm[2];
  logic [32:0] q[2][$];
  int          mode[2];
  logic [15:0] eseq[2];
  logic [31:0] epcnt[2];
  bit          stall[2];
  bit          done[2];
  logic [31:0] hold_d[2];
  logic [4:0]  hold_c[2];
  int          low_run[2];
  int          last_gap[2];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ftdi_tx_frame_source #(.PAYLOAD_WORDS(4), .GAP_CYCLES(4)) dut_a (
    .i_ftdi_clk(clk), .i_reset(rst), .i_enable(en[0]), .i_ready(rdy[0]),
    .o_valid(v[0]), .o_data(d[0]), .o_be(be[0]), .o_last(lst[0]),
    .o_frame_count(fc[0]), .o_busy(bsy[0]), .o_fsm(fsm[0]));

  ftdi_tx_frame_source #(.PAYLOAD_WORDS(255), .GAP_CYCLES(0)) dut_b (
    .i_ftdi_clk(clk), .i_reset(rst), .i_enable(en[1]), .i_ready(rdy[1]),
    .o_valid(v[1]), .o_data(d[1]), .o_be(be[1]), .o_last(lst[1]),
    .o_frame_count(fc[1]), .o_busy(bsy[1]), .o_fsm(fsm[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input int s, input int pw);
    logic [31:0] h;
    logic [31:0] cs;
    h = {16'hA5A5, eseq[s]};
    cs = h;
    q[s].push_back({1'b0, h});
    for (int i = 0; i < pw; i++) begin
      q[s].push_back({1'b0, epcnt[s]});
      cs ^= epcnt[s];
      epcnt[s]++;
    end
    q[s].push_back({1'b1, cs});
    eseq[s]++;
  endtask

  task automatic mon();
    logic [32:0] e;
    for (int s = 0; s < 2; s++) begin
      if (stall[s] && v[s]) begin
        chk($sformatf("hold_data%0d", s), d[s], hold_d[s]);
        chk($sformatf("hold_ctl%0d", s), {27'd0, be[s], lst[s]}, {27'd0, hold_c[s]});
      end
      stall[s]  = v[s] && !rdy[s];
      hold_d[s] = d[s];
      hold_c[s] = {be[s], lst[s]};
      if (v[s]) begin
        if (low_run[s] > 0) last_gap[s] = low_run[s];
        low_run[s] = 0;
      end else low_run[s]++;
      if (v[s] && rdy[s]) begin
        if (q[s].size() == 0) chk($sformatf("unexpected%0d", s), {31'd0, v[s]}, 32'd0);
        else begin
          e = q[s].pop_front();
          chk($sformatf("data%0d", s), d[s], e[31:0]);
          chk($sformatf("last%0d", s), {31'd0, lst[s]}, {31'd0, e[32]});
          chk($sformatf("be%0d", s), {28'd0, be[s]}, 32'hF);
          if (lst[s]) done[s] = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++)
        rdy[s] = mode[s] == 0 ? 1'b1 : mode[s] == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      mon();
    end
  endtask

  task automatic wait_last(input int s, input int budget);
    done[s] = 1'b0;
    for (int i = 0; i < budget && !done[s]; i++) cyc(1);
    chk($sformatf("timeout%0d", s), {31'd0, done[s]}, 32'd1);
  endtask

  initial begin
    en = '{1'b0, 1'b0};
    rdy = '{1'b1, 1'b1};
    mode = '{0, 0};
    eseq = '{16'd0, 16'd0};
    epcnt = '{32'd0, 32'd0};
    stall = '{1'b0, 1'b0};
    low_run = '{0, 0};
    last_gap = '{0, 0};
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, v[0]}, 32'd0);
    chk("rst_data", d[0], 32'd0);
    chk("rst_be", {28'd0, be[0]}, 32'd0);
    chk("rst_last", {31'd0, lst[0]}, 32'd0);
    chk("rst_count", {16'd0, fc[0]}, 32'd0);
    chk("rst_busy", {31'd0, bsy[0]}, 32'd0);
    chk("rst_fsm", {29'd0, fsm[0]}, 32'd0);
    chk("rst_valid_b", {31'd0, v[1]}, 32'd0);
    @(negedge clk) rst = 1'b0;
    cyc(2);
    // single frame, then the gap state
    push_frame(0, 4);
    en[0] = 1'b1;
    cyc(1);
    en[0] = 1'b0;
    wait_last(0, 20);
    cyc(1);
    chk("gap_fsm", {29'd0, fsm[0]}, 32'd4);
    chk("gap_busy", {31'd0, bsy[0]}, 32'd1);
    chk("gap_valid", {31'd0, v[0]}, 32'd0);
    chk("count1", {16'd0, fc[0]}, 32'd1);
    cyc(6);
    chk("idle_fsm", {29'd0, fsm[0]}, 32'd0);
    // frames 2 and 3 back to back, enable dropped mid-payload of frame 3
    push_frame(0, 4);
    push_frame(0, 4);
    en[0] = 1'b1;
    wait_last(0, 40);
    cyc(9);
    en[0] = 1'b0;
    chk("frame_gap", last_gap[0], 32'd5);
    chk("mid_fsm", {29'd0, fsm[0]}, 32'd2);
    wait_last(0, 20);
    cyc(10);
    chk("parked_fsm", {29'd0, fsm[0]}, 32'd0);
    chk("parked_valid", {31'd0, v[0]}, 32'd0);
    chk("count3", {16'd0, fc[0]}, 32'd3);
    // counter wrap
    force dut_a.r_pcnt = 32'hFFFF_FFFE;
    force dut_a.r_frame_count = 16'hFFFF;
    cyc(1);
    release dut_a.r_pcnt;
    release dut_a.r_frame_count;
    eseq[0] = 16'hFFFF;
    epcnt[0] = 32'hFFFF_FFFE;
    push_frame(0, 4);
    en[0] = 1'b1;
    cyc(1);
    en[0] = 1'b0;
    wait_last(0, 20);
    cyc(1);
    chk("count_wrap", {16'd0, fc[0]}, 32'd0);
    cyc(6);
    // reset while stalled mid-payload
    push_frame(0, 4);
    en[0] = 1'b1;
    cyc(1);
    en[0] = 1'b0;
    cyc(1);
    mode[0] = 2;
    cyc(2);
    chk("stalled_valid", {31'd0, v[0]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", {31'd0, v[0]}, 32'd0);
    chk("mrst_data", d[0], 32'd0);
    chk("mrst_fsm", {29'd0, fsm[0]}, 32'd0);
    q[0].delete();
    q[1].delete();
    eseq = '{16'd0, 16'd0};
    epcnt = '{32'd0, 32'd0};
    stall = '{1'b0, 1'b0};
    @(negedge clk) rst = 1'b0;
    mode[0] = 0;
    push_frame(0, 4);
    en[0] = 1'b1;
    cyc(1);
    en[0] = 1'b0;
    wait_last(0, 20);
    // gapless streaming on the long-frame instance
    push_frame(1, 255);
    push_frame(1, 255);
    en[1] = 1'b1;
    wait_last(1, 400);
    cyc(2);
    en[1] = 1'b0;
    wait_last(1, 400);
    chk("stream_gap", last_gap[1], 32'd1);
    cyc(3);
    // random back-pressure on a full 255-word frame
    mode[1] = 1;
    push_frame(1, 255);
    en[1] = 1'b1;
    cyc(1);
    en[1] = 1'b0;
    wait_last(1, 2000);
    mode[1] = 0;
    cyc(5);
    chk("count_b", {16'd0, fc[1]}, 32'd3);
    chk("sb_empty_a", q[0].size(), 32'd0);
    chk("sb_empty_b", q[1].size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
